// File: rtl/crc32_pkg.sv
// Shared constants and types for the CRC-32 frame checker.
package crc32_pkg;
  localparam int DATA_W = 8;
  localparam int CRC_W  = 32;
  localparam int LEN_W  = 16;

  localparam logic [CRC_W-1:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [CRC_W-1:0] CRC32_INIT      = 32'hFFFFFFFF;
  localparam logic [CRC_W-1:0] CRC32_RESIDUE   = 32'hDEBB20E3;

  // payload byte k is only released once byte k+4 arrives (FCS is 4 bytes)
  localparam logic [LEN_W-1:0] FCS_BYTES = 16'd4;
  localparam logic [LEN_W-1:0] MIN_LEN   = 16'd5;

  typedef enum logic [1:0] {IDLE, FILL, STREAM} chk_state_t;

  function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] v);
    return (v == {LEN_W{1'b1}}) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/crc32_byte_update.sv
// One reflected CRC-32 byte step, bit-serial form of (c>>8) ^ T[c[7:0]^byte].
module crc32_byte_update
  import crc32_pkg::*;
(
  input  logic [CRC_W-1:0]  crc_in,
  input  logic [DATA_W-1:0] data,
  output logic [CRC_W-1:0]  crc_out
);
  logic [CRC_W-1:0] c;

  always_comb begin
    c = crc_in ^ {{(CRC_W-DATA_W){1'b0}}, data};
    for (int i = 0; i < DATA_W; i++)
      c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
    crc_out = c;
  end
endmodule

// File: rtl/crc32_frame_checker.sv
// Receive-side CRC-32 checker: strips the FCS, forwards payload, reports status.
// Optional good/bad frame counters with CRC32_CHK_STATS_EN.
module crc32_frame_checker
  import crc32_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_sop,
  input  logic              in_eop,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_eop,
  input  logic              out_ready,
  output logic              frame_done,
  output logic              frame_ok,
  output logic              fcs_err,
  output logic              runt_err,
  output logic              abort_err,
  output logic [LEN_W-1:0]  frame_len
`ifdef CRC32_CHK_STATS_EN
  ,
  output logic [15:0]       good_cnt,
  output logic [15:0]       bad_cnt
`endif
);
  chk_state_t                  state_q;
  logic [CRC_W-1:0]            crc_q, crc_nxt;
  logic [LEN_W-1:0]            cnt_q, cnt_nxt;
  logic [3:0][DATA_W-1:0]      dl_q;
  logic                        acc, emit;

  assign in_ready = !out_valid || out_ready;
  assign acc      = in_valid && in_ready;
  assign cnt_nxt  = sat_inc(cnt_q);
  assign emit     = acc && !in_sop && (state_q != IDLE) && (cnt_q >= FCS_BYTES);

  crc32_byte_update u_step (
    .crc_in  (in_sop ? CRC32_INIT : crc_q),
    .data    (in_data),
    .crc_out (crc_nxt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      crc_q      <= CRC32_INIT;
      cnt_q      <= '0;
      dl_q       <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_eop    <= 1'b0;
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
      fcs_err    <= 1'b0;
      runt_err   <= 1'b0;
      abort_err  <= 1'b0;
      frame_len  <= '0;
    end else begin
      frame_done <= 1'b0;
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (emit) begin
        out_valid <= 1'b1;
        out_data  <= dl_q[3];
        out_eop   <= in_eop;
      end
      if (acc && in_sop) begin
        crc_q <= crc_nxt;
        cnt_q <= 16'd1;
        dl_q  <= {dl_q[2:0], in_data};
        // an open frame is closed as aborted; a same-byte eop then has no strobe of its own
        if (state_q != IDLE) begin
          frame_done <= 1'b1;
          {frame_ok, fcs_err, runt_err, abort_err} <= 4'b0001;
          frame_len  <= cnt_q;
        end else if (in_eop) begin
          frame_done <= 1'b1;
          {frame_ok, fcs_err, runt_err, abort_err} <= 4'b0010;
          frame_len  <= 16'd1;
        end
        state_q <= in_eop ? IDLE : FILL;
      end else if (acc && state_q != IDLE) begin
        crc_q <= crc_nxt;
        cnt_q <= cnt_nxt;
        dl_q  <= {dl_q[2:0], in_data};
        if (in_eop) begin
          state_q    <= IDLE;
          frame_done <= 1'b1;
          frame_len  <= cnt_nxt;
          if (cnt_nxt < MIN_LEN)
            {frame_ok, fcs_err, runt_err, abort_err} <= 4'b0010;
          else if (crc_nxt == CRC32_RESIDUE)
            {frame_ok, fcs_err, runt_err, abort_err} <= 4'b1000;
          else
            {frame_ok, fcs_err, runt_err, abort_err} <= 4'b0100;
        end else begin
          state_q <= (cnt_q >= FCS_BYTES) ? STREAM : FILL;
        end
      end
    end
  end

`ifdef CRC32_CHK_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      good_cnt <= '0;
      bad_cnt  <= '0;
    end else if (frame_done) begin
      if (frame_ok) good_cnt <= sat_inc(good_cnt);
      if (fcs_err || runt_err || abort_err) bad_cnt <= sat_inc(bad_cnt);
    end
  end
`endif
endmodule

// File: tb/tb_crc32_frame_checker.sv
// Self-checking bench for crc32_frame_checker: table vectors, corner sequences, random frames.
module tb_crc32_frame_checker;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_valid, in_sop, in_eop, in_ready;
  logic [7:0]  out_data;
  logic        out_valid, out_eop, out_ready;
  logic        frame_done, frame_ok, fcs_err, runt_err, abort_err;
  logic [15:0] frame_len;
`ifdef CRC32_CHK_STATS_EN
  logic [15:0] good_cnt, bad_cnt;
`endif

  always #5 clk = ~clk;

  crc32_frame_checker dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
    .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_eop(out_eop), .out_ready(out_ready),
    .frame_done(frame_done), .frame_ok(frame_ok), .fcs_err(fcs_err),
    .runt_err(runt_err), .abort_err(abort_err), .frame_len(frame_len)
`ifdef CRC32_CHK_STATS_EN
    , .good_cnt(good_cnt), .bad_cnt(bad_cnt)
`endif
  );

  typedef struct { logic [7:0] d; logic e; } ob_t;
  typedef struct { logic ok, fcs, runt, abort; logic [15:0] len; } st_t;
  typedef struct {
    logic [0:15][7:0] b;
    int               n;
    logic             ok, fcs, runt;
    int               len;
    int               nout;
  } vec_t;

  ob_t got_q[$], exp_q[$];
  st_t got_st[$], exp_st[$];
  int  n_pass = 0, n_tot = 0;
  int  exp_good = 0, exp_bad = 0;
  bit  rand_rdy = 0, force_low = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // standard reflected CRC-32 of a byte string, finalized
  function automatic logic [31:0] crc32(input logic [7:0] q[$], input int n);
    logic [31:0] c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c ^= {24'h0, q[i]};
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  // expected outputs and status for a frame closed by eop (closed=1) or by a later sop
  task automatic model_frame(input logic [7:0] q[$], input bit closed);
    int n = q.size();
    st_t s = '{ok:0, fcs:0, runt:0, abort:0, len:n[15:0]};
    for (int i = 0; i < n - 4; i++) exp_q.push_back('{d:q[i], e:(closed && i == n - 5)});
    if (!closed) s.abort = 1;
    else if (n < 5) s.runt = 1;
    else if (crc32(q, n - 4) == {q[n-1], q[n-2], q[n-3], q[n-4]}) s.ok = 1;
    else s.fcs = 1;
    exp_st.push_back(s);
    if (s.ok) exp_good++; else exp_bad++;
  endtask

  always @(negedge clk)
    out_ready = force_low ? 1'b0 : (rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1);

  always @(negedge clk) begin
    #1;
    if (rst_n && out_valid && out_ready) got_q.push_back('{d:out_data, e:out_eop});
  end

  always @(negedge clk)
    if (frame_done)
      got_st.push_back('{ok:frame_ok, fcs:fcs_err, runt:runt_err, abort:abort_err, len:frame_len});

  // call at a negedge; returns at a negedge
  task automatic send(input logic [7:0] q[$], input bit with_eop, input bit gaps);
    int t;
    for (int i = 0; i < q.size(); i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 0; in_sop = 0; in_eop = 0;
        @(negedge clk);
      end
      in_valid = 1; in_data = q[i]; in_sop = (i == 0); in_eop = with_eop && (i == q.size() - 1);
      #1;
      t = 0;
      while (!in_ready && t < 500) begin @(negedge clk); #1; t++; end
      if (!in_ready) begin
        chk("in_ready_timeout", 32'd0, 32'd1);
        break;
      end
      @(negedge clk);
    end
    in_valid = 0; in_sop = 0; in_eop = 0;
  endtask

  task automatic compare(input string tag);
    int t = 0;
    repeat (3) @(negedge clk);
    while (out_valid && t < 300) begin @(negedge clk); t++; end
    if (out_valid) chk({tag, "_drain"}, 32'd0, 32'd1);
    repeat (2) @(negedge clk);
    chk({tag, "_nout"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      chk($sformatf("%s_data%0d", tag, i), got_q[i].d, exp_q[i].d);
      chk($sformatf("%s_eop%0d", tag, i), got_q[i].e, exp_q[i].e);
    end
    chk({tag, "_nstat"}, got_st.size(), exp_st.size());
    for (int i = 0; i < got_st.size() && i < exp_st.size(); i++) begin
      chk($sformatf("%s_st%0d", tag, i),
          {got_st[i].ok, got_st[i].fcs, got_st[i].runt, got_st[i].abort},
          {exp_st[i].ok, exp_st[i].fcs, exp_st[i].runt, exp_st[i].abort});
      chk($sformatf("%s_len%0d", tag, i), got_st[i].len, exp_st[i].len);
    end
`ifdef CRC32_CHK_STATS_EN
    chk({tag, "_good_cnt"}, good_cnt, exp_good);
    chk({tag, "_bad_cnt"}, bad_cnt, exp_bad);
`endif
    got_q.delete(); exp_q.delete(); got_st.delete(); exp_st.delete();
  endtask

  function automatic void vec_bytes(input vec_t v, output logic [7:0] q[$]);
    q.delete();
    for (int i = 0; i < v.n; i++) q.push_back(v.b[i]);
  endfunction

  vec_t tv[4];

  initial begin
    logic [7:0] q[$];
    logic [7:0] good13[$];

    tv[0] = '{b:{8'h31,8'h32,8'h33,8'h34,8'h35,8'h36,8'h37,8'h38,8'h39,8'h26,8'h39,8'hF4,8'hCB,24'h0},
              n:13, ok:1, fcs:0, runt:0, len:13, nout:9};
    tv[1] = '{b:{8'h31,8'h32,8'h33,8'h34,8'h35,8'h36,8'h37,8'h38,8'h39,8'h27,8'h39,8'hF4,8'hCB,24'h0},
              n:13, ok:0, fcs:1, runt:0, len:13, nout:9};
    tv[2] = '{b:{8'h00,8'h8D,8'hEF,8'h02,8'hD2,88'h0}, n:5, ok:1, fcs:0, runt:0, len:5, nout:1};
    tv[3] = '{b:128'h0, n:4, ok:0, fcs:0, runt:1, len:4, nout:0};

    rst_n = 0; in_valid = 0; in_sop = 0; in_eop = 0; in_data = 0;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_eop", out_eop, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_status", {frame_ok, fcs_err, runt_err, abort_err}, 0);
    chk("rst_frame_len", frame_len, 0);
`ifdef CRC32_CHK_STATS_EN
    chk("rst_good_cnt", good_cnt, 0);
    chk("rst_bad_cnt", bad_cnt, 0);
`endif
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    // table vectors, expectations straight from the table
    for (int k = 0; k < 4; k++) begin
      vec_bytes(tv[k], q);
      for (int i = 0; i < tv[k].nout; i++) exp_q.push_back('{d:tv[k].b[i], e:(i == tv[k].nout - 1)});
      exp_st.push_back('{ok:tv[k].ok, fcs:tv[k].fcs, runt:tv[k].runt, abort:0, len:tv[k].len[15:0]});
      if (tv[k].ok) exp_good++; else exp_bad++;
      send(q, 1, 0);
      compare($sformatf("vec%0d", k));
    end

    // consumer stall of 3 cycles mid-payload
    vec_bytes(tv[0], good13);
    model_frame(good13, 1);
    fork
      send(good13, 1, 0);
      begin
        int t = 0;
        @(negedge clk); #2;
        while (!out_valid && t < 100) begin @(negedge clk); #2; t++; end
        force_low = 1;
        repeat (3) begin
          @(negedge clk); #2;
          chk("stall_in_ready", in_ready, 0);
          chk("stall_out_valid", out_valid, 1);
        end
        force_low = 0;
      end
    join
    compare("stall");

    // abort at byte 7, then a clean frame
    q = good13[0:5];
    model_frame(q, 0);
    send(q, 0, 0);
    model_frame(good13, 1);
    send(good13, 1, 0);
    compare("abort");

    // reset mid-frame discards everything and emits no status
    q = good13[0:6];
    send(q, 0, 0);
    repeat (3) @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    #2;
    chk("midrst_out_valid", out_valid, 0);
    got_q.delete(); got_st.delete();
    exp_good = 0; exp_bad = 0;
    @(negedge clk);
    model_frame(good13, 1);
    send(good13, 1, 0);
    compare("post_reset");

    // random frames, back-to-back or gapped, random consumer backpressure
    rand_rdy = 1;
    for (int f = 0; f < 40; f++) begin
      int pl = $urandom_range(0, 20);
      bit gaps = $urandom_range(0, 1);
      q.delete();
      if (pl == 0) begin
        repeat ($urandom_range(1, 4)) q.push_back(8'($urandom));
      end else begin
        logic [31:0] c;
        repeat (pl) q.push_back(8'($urandom));
        c = crc32(q, pl);
        q.push_back(c[7:0]); q.push_back(c[15:8]); q.push_back(c[23:16]); q.push_back(c[31:24]);
        if ($urandom_range(0, 3) == 0) begin
          int idx = $urandom_range(0, q.size() - 1);
          q[idx] ^= 8'(1 << $urandom_range(0, 7));
        end
      end
      if (f != 39 && $urandom_range(0, 7) == 0) begin
        model_frame(q, 0);
        send(q, 0, gaps);
      end else begin
        model_frame(q, 1);
        send(q, 1, gaps);
      end
    end
    rand_rdy = 0;
    compare("rand");

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
